// File: rtl/instruction_package.sv
// Shared definitions for the regex CPU datapath: the program-counter type and
// the channel-count helper used by the PC work queue.
package instruction_package;

    localparam int PC_WIDTH   = 9;
    localparam int CC_ID_BITS = 2;
    localparam int N_CH       = 2 ** CC_ID_BITS;

    typedef logic [PC_WIDTH-1:0] pc_t;

endpackage

// File: rtl/regex_pc_fifo.sv
// Single-channel circular PC FIFO: accepts zero, one or two PCs per cycle,
// pops one, and clears instantly on flush.
module regex_pc_fifo #(
    parameter int PC_WIDTH   = 9,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            push_count,
    input  logic [PC_WIDTH-1:0]   push_pc0,
    input  logic [PC_WIDTH-1:0]   push_pc1,
    input  logic                  pop,
    input  logic                  flush,
    output logic [PC_WIDTH-1:0]   head,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int D  = 2 ** DEPTH_LOG2;
    localparam int CW = DEPTH_LOG2 + 1;

    logic [PC_WIDTH-1:0]   mem [D];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr_plus1;

    assign wr_ptr_plus1 = wr_ptr + DEPTH_LOG2'(1);
    assign head         = mem[rd_ptr];

    // Flush takes priority over any simultaneous push or pop on this channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + DEPTH_LOG2'(push_count);
            if (pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            count <= count + CW'(push_count) - CW'(pop);
        end
    end

    // pc0 lands in the older slot so it is popped before pc1.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (push_count != 2'd0) begin
                mem[wr_ptr] <= push_pc0;
            end
            if (push_count == 2'd2) begin
                mem[wr_ptr_plus1] <= push_pc1;
            end
        end
    end

endmodule

// File: rtl/regex_split_pc_buffer.sv
// Multi-channel PC work queue: one FIFO per character channel, a round-robin
// arbiter and a single output register feeding the regex CPUs.
module regex_split_pc_buffer #(
    parameter int PC_WIDTH              = 9,
    parameter int CC_ID_BITS            = 2,
    parameter int FIFO_WIDTH_POWER_OF_2 = 2,
    localparam int N_CH                 = 2 ** CC_ID_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [CC_ID_BITS-1:0] in_cc_id,
    input  logic [PC_WIDTH-1:0]   in_pc0,
    input  logic                  in_pc1_valid,
    input  logic [PC_WIDTH-1:0]   in_pc1,
    output logic                  in_ready,
    input  logic [N_CH-1:0]       flush,
    output logic                  out_valid,
    output logic [CC_ID_BITS-1:0] out_cc_id,
    output logic [PC_WIDTH-1:0]   out_pc,
    input  logic                  out_ready,
    output logic [N_CH-1:0]       channel_pending,
    output logic                  running
);

    import instruction_package::*;

    localparam int D  = 2 ** FIFO_WIDTH_POWER_OF_2;
    localparam int CW = FIFO_WIDTH_POWER_OF_2 + 1;

    logic [CW-1:0]         count [N_CH];
    logic [PC_WIDTH-1:0]   head [N_CH];
    logic [1:0]            push_count [N_CH];
    logic [N_CH-1:0]       nonempty;
    logic [N_CH-1:0]       eligible;
    logic [N_CH-1:0]       pop;
    logic [1:0]            need;
    logic [CW-1:0]         free_slots;
    logic                  accept;
    logic                  load;
    logic                  grant_found;
    logic [CC_ID_BITS-1:0] grant_id;
    logic [CC_ID_BITS-1:0] scan_id;
    logic [CC_ID_BITS-1:0] rr_ptr;

    // Identical SPLIT targets collapse into a single entry.
    assign need       = (in_pc1_valid && (in_pc1 != in_pc0)) ? 2'd2 : 2'd1;
    assign free_slots = CW'(D) - count[in_cc_id];
    assign in_ready   = rst_n & ~flush[in_cc_id] & (free_slots >= CW'(need));
    assign accept     = in_valid & in_ready;
    assign load       = ~out_valid | out_ready;
    assign eligible   = nonempty & ~flush;

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_ch
            assign nonempty[g]   = (count[g] != '0);
            assign push_count[g] = (accept && (in_cc_id == CC_ID_BITS'(g))) ? need : 2'd0;
            assign pop[g]        = load & grant_found & (grant_id == CC_ID_BITS'(g));
            assign channel_pending[g] = nonempty[g] |
                                        (out_valid & (out_cc_id == CC_ID_BITS'(g)));

            regex_pc_fifo #(
                .PC_WIDTH   (PC_WIDTH),
                .DEPTH_LOG2 (FIFO_WIDTH_POWER_OF_2)
            ) u_fifo (
                .clk        (clk),
                .rst_n      (rst_n),
                .push_count (push_count[g]),
                .push_pc0   (in_pc0),
                .push_pc1   (in_pc1),
                .pop        (pop[g]),
                .flush      (flush[g]),
                .head       (head[g]),
                .count      (count[g])
            );
        end
    endgenerate

    assign running = |channel_pending;

    // First eligible channel at or after the pointer; flushed channels are skipped.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_id     = '0;
        for (int k = 0; k < N_CH; k++) begin
            scan_id = rr_ptr + CC_ID_BITS'(k);
            if (!grant_found && eligible[scan_id]) begin
                grant_found = 1'b1;
                grant_id    = scan_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_cc_id <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            out_valid <= grant_found;
            if (grant_found) begin
                out_pc    <= head[grant_id];
                out_cc_id <= grant_id;
                rr_ptr    <= grant_id + CC_ID_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_regex_split_pc_buffer.sv
// Directed bench for regex_split_pc_buffer with per-channel expected queues
// and an independent output monitor.
module tb_regex_split_pc_buffer;

    import instruction_package::*;

    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic [1:0]     in_cc_id;
    pc_t            in_pc0;
    logic           in_pc1_valid;
    pc_t            in_pc1;
    logic           in_ready;
    logic [NCH-1:0] flush;
    logic           out_valid;
    logic [1:0]     out_cc_id;
    pc_t            out_pc;
    logic           out_ready;
    logic [NCH-1:0] channel_pending;
    logic           running;

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cycle        = 0;
    pc_t  exp_q [NCH][$];
    logic [1:0] obs_cc [$];
    int   obs_cyc [$];
    pc_t  mon_exp;

    regex_split_pc_buffer #(
        .PC_WIDTH              (9),
        .CC_ID_BITS            (2),
        .FIFO_WIDTH_POWER_OF_2 (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_cc_id        (in_cc_id),
        .in_pc0          (in_pc0),
        .in_pc1_valid    (in_pc1_valid),
        .in_pc1          (in_pc1),
        .in_ready        (in_ready),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_cc_id       (out_cc_id),
        .out_pc          (out_pc),
        .out_ready       (out_ready),
        .channel_pending (channel_pending),
        .running         (running)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Every handshake is matched against the head of its channel's expected queue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            obs_cc.push_back(out_cc_id);
            obs_cyc.push_back(cycle);
            tests_run++;
            if (exp_q[out_cc_id].size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL unexpected_output: got pc %0h on cc%0d, expected nothing",
                         out_pc, out_cc_id);
            end else begin
                mon_exp = exp_q[out_cc_id].pop_front();
                if (out_pc !== mon_exp) begin
                    tests_failed++;
                    $display("[TB] FAIL out_pc_cc%0d: got %0h, expected %0h",
                             out_cc_id, out_pc, mon_exp);
                end
            end
        end
    end

    task automatic apply_stimulus(input logic [1:0] cc, input pc_t pc0, input logic pc1v,
                                  input pc_t pc1, input logic expect_ready);
        @(posedge clk);
        #1;
        in_valid     = 1'b1;
        in_cc_id     = cc;
        in_pc0       = pc0;
        in_pc1_valid = pc1v;
        in_pc1       = pc1;
        #1;
        check_output($sformatf("in_ready_cc%0d_pc%0h", cc, pc0), 32'(in_ready), 32'(expect_ready));
        if (expect_ready) begin
            exp_q[cc].push_back(pc0);
            if (pc1v && (pc1 != pc0)) exp_q[cc].push_back(pc1);
        end
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        in_pc1_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!running && exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
                exp_q[2].size() == 0 && exp_q[3].size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s_timeout: drain not complete after %0d cycles", name, budget);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int busy_cycles;
        logic [1:0] exp_order [8];
        exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_cc_id     = 2'd0;
        in_pc0       = '0;
        in_pc1_valid = 1'b0;
        in_pc1       = '0;
        flush        = '0;
        out_ready    = 1'b1;

        // Reset and idle behaviour.
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_out_valid", 32'(out_valid), 0);
        check_output("reset_out_pc", 32'(out_pc), 0);
        check_output("reset_running", 32'(running), 0);
        check_output("reset_in_ready", 32'(in_ready), 0);
        rst_n = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            in_cc_id = 2'(c);
            #1;
            check_output($sformatf("idle_in_ready_cc%0d", c), 32'(in_ready), 1);
        end
        busy_cycles = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid || running) busy_cycles++;
        end
        check_output("idle_quiet_cycles", 32'(busy_cycles), 0);

        // SPLIT pair on cc2 drains in push order.
        apply_stimulus(2'd2, 9'h0F6, 1'b1, 9'h040, 1'b1);
        wait_idle(50, "split_pair");
        check_output("split_running_after", 32'(running), 0);

        // Equal PCs occupy one slot: two further pairs fit, a third does not.
        @(posedge clk); #1; out_ready = 1'b0;
        apply_stimulus(2'd1, 9'h105, 1'b1, 9'h105, 1'b1);
        apply_stimulus(2'd1, 9'h106, 1'b1, 9'h107, 1'b1);
        apply_stimulus(2'd1, 9'h108, 1'b1, 9'h109, 1'b1);
        apply_stimulus(2'd1, 9'h10A, 1'b1, 9'h10B, 1'b0);
        apply_stimulus(2'd1, 9'h10C, 1'b0, 9'h000, 1'b0);
        @(posedge clk); #1; out_ready = 1'b1;
        wait_idle(50, "dedup");

        // Fill cc0 to capacity while another channel keeps accepting.
        @(posedge clk); #1; out_ready = 1'b0;
        apply_stimulus(2'd0, 9'h001, 1'b1, 9'h002, 1'b1);
        apply_stimulus(2'd0, 9'h003, 1'b1, 9'h004, 1'b1);
        apply_stimulus(2'd0, 9'h005, 1'b1, 9'h006, 1'b0);
        apply_stimulus(2'd0, 9'h005, 1'b0, 9'h000, 1'b1);
        apply_stimulus(2'd0, 9'h006, 1'b0, 9'h000, 1'b0);
        apply_stimulus(2'd3, 9'h033, 1'b0, 9'h000, 1'b1);
        check_output("full_out_pc_held", 32'(out_pc), 32'h001);
        @(posedge clk); #1; out_ready = 1'b1;
        wait_idle(50, "full");

        // Round robin across four loaded channels, one PC per cycle.
        @(posedge clk); #1; out_ready = 1'b0;
        apply_stimulus(2'd0, 9'h010, 1'b1, 9'h011, 1'b1);
        apply_stimulus(2'd1, 9'h020, 1'b1, 9'h021, 1'b1);
        apply_stimulus(2'd2, 9'h030, 1'b1, 9'h031, 1'b1);
        apply_stimulus(2'd3, 9'h040, 1'b1, 9'h041, 1'b1);
        obs_cc.delete();
        obs_cyc.delete();
        @(posedge clk); #1; out_ready = 1'b1;
        wait_idle(50, "round_robin");
        check_output("rr_count", 32'(obs_cc.size()), 8);
        if (obs_cc.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check_output($sformatf("rr_order_%0d", i), 32'(obs_cc[i]), 32'(exp_order[i]));
            end
            check_output("rr_back_to_back", 32'(obs_cyc[7] - obs_cyc[0]), 7);
        end

        // Flush cc1 while its head sits in the output register.
        @(posedge clk); #1; out_ready = 1'b0;
        apply_stimulus(2'd1, 9'h051, 1'b1, 9'h052, 1'b1);
        apply_stimulus(2'd1, 9'h053, 1'b1, 9'h054, 1'b1);
        check_output("flush_head_valid", 32'(out_valid), 1);
        check_output("flush_head_pc", 32'(out_pc), 32'h051);
        flush        = 4'b0010;
        in_valid     = 1'b1;
        in_cc_id     = 2'd1;
        in_pc0       = 9'h055;
        in_pc1_valid = 1'b0;
        out_ready    = 1'b1;
        exp_q[1].delete();
        exp_q[1].push_back(9'h051);
        #1;
        check_output("flush_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        flush    = '0;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_output("flush_pending_cc1", 32'(channel_pending[1]), 0);
        check_output("flush_out_valid", 32'(out_valid), 0);
        check_output("flush_running", 32'(running), 0);

        for (int c = 0; c < NCH; c++) begin
            check_output($sformatf("leftover_cc%0d", c), 32'(exp_q[c].size()), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
